// File: rtl/prv32_div_sequencer.sv
// ----------------------------------------------------------------------------
// prv32_div_sequencer
//   Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU) that sits
//   beside the EX-stage ALU. Uses a restoring divider that produces one
//   quotient bit per cycle. Divide-by-zero and signed overflow are resolved
//   in the accept cycle without iterating.
//
// Ports
//   clk     : system clock, rising edge
//   rst     : asynchronous active-low reset
//   start   : issue request, sampled only while idle
//   flush   : synchronous abort of an in-flight op (no done, result kept)
//   alufn   : ALU function; [4:2] must be 3'b110, [1:0] selects the op
//             00 DIV, 01 DIVU, 10 REM, 11 REMU
//   a, b    : dividend / divisor, latched on accept
//   busy    : high in every state except idle (pipeline stall)
//   done    : one-cycle pulse, result valid
//   result  : quotient or remainder, held until the next accepted start
//   dz      : divisor was zero, same timing and hold as result
// ----------------------------------------------------------------------------
module prv32_div_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [4:0]      alufn,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            dz
);

  localparam int unsigned     CW      = $clog2(XLEN);
  localparam logic [2:0]      DIV_GRP = 3'b110;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // Working registers
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] dvd;     // dividend shifting out, quotient shifting in
  logic [XLEN-1:0] dvs;     // divisor magnitude
  logic [XLEN-1:0] rem;     // partial remainder
  logic            neg_q;
  logic            neg_r;
  logic            op_rem;

  // Decode of the request presented in the accept cycle
  logic            sgn_c;
  logic            rem_sel_c;
  logic            accept_c;
  logic            div_zero_c;
  logic            overflow_c;
  logic            special_c;
  logic [XLEN-1:0] special_res_c;
  logic [XLEN-1:0] abs_a_c;
  logic [XLEN-1:0] abs_b_c;

  assign sgn_c      = ~alufn[0];
  assign rem_sel_c  = alufn[1];
  assign accept_c   = (state == S_IDLE) && start && (alufn[4:2] == DIV_GRP);
  assign div_zero_c = (b == '0);
  assign overflow_c = sgn_c && (a == MIN_NEG) && (b == ALL_ONE);
  assign special_c  = div_zero_c || overflow_c;
  assign abs_a_c    = (sgn_c && a[XLEN-1]) ? (~a + XLEN'(1)) : a;
  assign abs_b_c    = (sgn_c && b[XLEN-1]) ? (~b + XLEN'(1)) : b;

  // Divide-by-zero takes priority; overflow can only occur with b != 0.
  always_comb begin
    special_res_c = '0;
    if (div_zero_c) begin
      special_res_c = rem_sel_c ? a : ALL_ONE;
    end else if (overflow_c) begin
      special_res_c = rem_sel_c ? '0 : MIN_NEG;
    end
  end

  // One restoring step; the extra top bit keeps the compare overflow-free.
  logic [XLEN:0]   shift_c;
  logic [XLEN:0]   diff_c;
  logic            ge_c;
  logic [XLEN-1:0] rem_nxt_c;
  logic [XLEN-1:0] dvd_nxt_c;

  assign shift_c   = {rem, dvd[XLEN-1]};
  assign diff_c    = shift_c - {1'b0, dvs};
  assign ge_c      = (shift_c >= {1'b0, dvs});
  assign rem_nxt_c = ge_c ? diff_c[XLEN-1:0] : shift_c[XLEN-1:0];
  assign dvd_nxt_c = {dvd[XLEN-2:0], ge_c};

  // Sign correction and quotient/remainder select
  logic [XLEN-1:0] q_fix_c;
  logic [XLEN-1:0] r_fix_c;
  logic [XLEN-1:0] fix_res_c;

  assign q_fix_c   = neg_q ? (~dvd + XLEN'(1)) : dvd;
  assign r_fix_c   = neg_r ? (~rem + XLEN'(1)) : rem;
  assign fix_res_c = op_rem ? r_fix_c : q_fix_c;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; flush overrides every non-idle transition
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept_c) begin
          state_nxt = special_c ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (cnt == CW'(XLEN-1)) begin
          state_nxt = S_FIX;
        end
      end
      S_FIX:  state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush && (state != S_IDLE)) begin
      state_nxt = S_IDLE;
    end
  end

  // Datapath: operand setup on accept, one iteration per CALC cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      dvd    <= '0;
      dvs    <= '0;
      rem    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      op_rem <= 1'b0;
    end else if (accept_c) begin
      cnt    <= '0;
      dvd    <= abs_a_c;
      dvs    <= abs_b_c;
      rem    <= '0;
      neg_q  <= sgn_c && (a[XLEN-1] ^ b[XLEN-1]);
      neg_r  <= sgn_c && a[XLEN-1];
      op_rem <= rem_sel_c;
    end else if (state == S_CALC) begin
      cnt <= cnt + CW'(1);
      dvd <= dvd_nxt_c;
      rem <= rem_nxt_c;
    end
  end

  // Registered outputs; result/dz change only on entry to DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      dz     <= 1'b0;
    end else begin
      busy <= (state_nxt != S_IDLE);
      done <= (state_nxt == S_DONE);
      if (state_nxt == S_DONE) begin
        if (state == S_IDLE) begin
          result <= special_res_c;
          dz     <= div_zero_c;
        end else begin
          result <= fix_res_c;
          dz     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_prv32_div_sequencer.sv
// ----------------------------------------------------------------------------
// tb_prv32_div_sequencer
//   Self-checking bench: directed vector table, hand-written abort/ignore
//   sequences, and randomized back-to-back ops against an arithmetic model.
// ----------------------------------------------------------------------------
module tb_prv32_div_sequencer;

  localparam int unsigned     XLEN    = 32;
  localparam logic [XLEN-1:0] MIN_NEG = 32'h8000_0000;
  localparam logic [4:0]      F_DIV   = 5'b110_00;
  localparam logic [4:0]      F_DIVU  = 5'b110_01;
  localparam logic [4:0]      F_REM   = 5'b110_10;
  localparam logic [4:0]      F_REMU  = 5'b110_11;
  localparam int              LAT_N   = 34;
  localparam int              LAT_S   = 1;

  logic            clk   = 1'b0;
  logic            rst   = 1'b1;
  logic            start = 1'b0;
  logic            flush = 1'b0;
  logic [4:0]      alufn = '0;
  logic [XLEN-1:0] a     = '0;
  logic [XLEN-1:0] b     = '0;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            dz;

  int checks    = 0;
  int errors    = 0;
  int done_seen = 0;
  int exp_dones = 0;

  always #5 clk = ~clk;

  prv32_div_sequencer #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .flush  (flush),
    .alufn  (alufn),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .dz     (dz)
  );

  always @(negedge clk) if (done) done_seen++;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: RISC-V divide semantics from plain integer arithmetic.
  function automatic logic [XLEN:0] ref_op(input logic [1:0] op,
                                           input logic [XLEN-1:0] x,
                                           input logic [XLEN-1:0] y);
    int              sx;
    int              sy;
    logic [XLEN-1:0] r;
    logic            z;
    sx = $signed(x);
    sy = $signed(y);
    z  = (y == '0);
    r  = '0;
    if (z) begin
      r = op[1] ? x : '1;
    end else if (!op[0] && x == MIN_NEG && y == '1) begin
      r = op[1] ? '0 : MIN_NEG;
    end else begin
      case (op)
        2'b00:   r = XLEN'(sx / sy);
        2'b01:   r = x / y;
        2'b10:   r = XLEN'(sx % sy);
        default: r = x % y;
      endcase
    end
    return {z, r};
  endfunction

  // Issue one op in the cycle after the current one; wait for done.
  task automatic run_op(input logic [4:0] fn, input logic [XLEN-1:0] x,
                        input logic [XLEN-1:0] y, output logic [XLEN-1:0] res,
                        output logic z, output int lat, output int busy_cyc);
    @(posedge clk); #1;
    start = 1'b1; alufn = fn; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; alufn = 5'($urandom);
    exp_dones++;
    lat = 0; busy_cyc = 0; res = '0; z = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (done) begin
        lat = i; res = result; z = dz;
        break;
      end
    end
  endtask

  typedef struct {
    logic [4:0]      fn;
    logic [XLEN-1:0] x;
    logic [XLEN-1:0] y;
    logic [XLEN-1:0] res;
    logic            z;
    int              lat;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [XLEN-1:0] res;
    logic            z;
    logic [XLEN:0]   exp;
    int              lat;
    int              bc;
    int              d0;
    logic [4:0]      fn;
    logic [XLEN-1:0] x;
    logic [XLEN-1:0] y;
    int              sel;

    vecs[0]  = '{F_DIV,  32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 1'b0, LAT_N};
    vecs[1]  = '{F_REM,  32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 1'b0, LAT_N};
    vecs[2]  = '{F_DIVU, 32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF, 1'b0, LAT_N};
    vecs[3]  = '{F_REMU, 32'hFFFF_FFFF, 32'h10,        32'h0000_000F, 1'b0, LAT_N};
    vecs[4]  = '{F_DIV,  32'h7,         32'h0,         32'hFFFF_FFFF, 1'b1, LAT_S};
    vecs[5]  = '{F_REM,  32'h7,         32'h0,         32'h0000_0007, 1'b1, LAT_S};
    vecs[6]  = '{F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, LAT_S};
    vecs[7]  = '{F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, LAT_S};
    vecs[8]  = '{F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, LAT_N};
    vecs[9]  = '{F_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, LAT_N};
    vecs[10] = '{F_DIV,  32'h7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, LAT_N};
    vecs[11] = '{F_REM,  32'h7,         32'hFFFF_FFFE, 32'h0000_0001, 1'b0, LAT_N};
    vecs[12] = '{F_DIV,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0, LAT_N};
    vecs[13] = '{F_REMU, 32'h5,         32'h0,         32'h0000_0005, 1'b1, LAT_S};

    // Reset
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", XLEN'(busy), '0);
    check("reset done", XLEN'(done), '0);
    check("reset result", result, '0);
    check("reset dz", XLEN'(dz), '0);
    rst = 1'b1;

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].fn, vecs[i].x, vecs[i].y, res, z, lat, bc);
      check($sformatf("vec%0d result", i), res, vecs[i].res);
      check($sformatf("vec%0d dz", i), XLEN'(z), XLEN'(vecs[i].z));
      check($sformatf("vec%0d latency", i), XLEN'(lat), XLEN'(vecs[i].lat));
      check($sformatf("vec%0d busy cycles", i), XLEN'(bc), XLEN'(vecs[i].lat));
      @(negedge clk);
      check($sformatf("vec%0d done pulse", i), XLEN'(done), '0);
      check($sformatf("vec%0d busy after", i), XLEN'(busy), '0);
      check($sformatf("vec%0d result hold", i), result, vecs[i].res);
    end

    // Flush at cycle 10 of a DIVU: no done, result kept
    run_op(F_DIVU, 32'd100, 32'd7, res, z, lat, bc);
    check("pre-flush result", res, 32'd14);
    @(posedge clk); #1;
    start = 1'b1; alufn = F_DIVU; a = 32'hFFFF_0000; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("flush busy", XLEN'(busy), '0);
    d0 = done_seen;
    repeat (40) @(negedge clk);
    check("flush no done", XLEN'(done_seen - d0), '0);
    check("flush result kept", result, 32'd14);
    check("flush dz kept", XLEN'(dz), '0);

    // start while busy is ignored
    d0 = done_seen;
    @(posedge clk); #1;
    start = 1'b1; alufn = F_DIVU; a = 32'd1000; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    exp_dones++;
    repeat (4) @(posedge clk);
    #1 start = 1'b1; alufn = F_REMU; a = 32'd55; b = 32'd0;
    @(posedge clk); #1 start = 1'b0;
    lat = 0;
    for (int i = 6; i <= 100; i++) begin
      @(negedge clk);
      if (done) begin lat = i; break; end
    end
    check("busy-start latency", XLEN'(lat), XLEN'(LAT_N));
    check("busy-start result", result, 32'd142);
    check("busy-start dz", XLEN'(dz), '0);
    repeat (40) @(negedge clk);
    check("busy-start one done", XLEN'(done_seen - d0), 32'd1);

    // Wrong function group is ignored
    d0 = done_seen;
    @(posedge clk); #1;
    start = 1'b1; alufn = 5'b000_00; a = 32'd7; b = 32'd0;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("bad alufn busy", XLEN'(busy), '0);
    repeat (5) @(negedge clk);
    check("bad alufn no done", XLEN'(done_seen - d0), '0);
    check("bad alufn result", result, 32'd142);

    // Reset mid-CALC aborts immediately
    d0 = done_seen;
    @(posedge clk); #1;
    start = 1'b1; alufn = F_DIVU; a = 32'h1234_5678; b = 32'd9;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("midreset busy", XLEN'(busy), '0);
    check("midreset done", XLEN'(done), '0);
    check("midreset result", result, '0);
    check("midreset dz", XLEN'(dz), '0);
    @(negedge clk) rst = 1'b1;
    repeat (40) @(negedge clk);
    check("midreset no done", XLEN'(done_seen - d0), '0);

    // Randomized back-to-back ops against the model
    for (int n = 0; n < 1000; n++) begin
      fn  = {3'b110, 2'($urandom_range(0, 3))};
      x   = $urandom;
      y   = $urandom;
      sel = $urandom_range(0, 19);
      if (sel == 0) y = '0;
      else if (sel == 1) begin x = MIN_NEG; y = '1; end
      else if (sel < 6) y = XLEN'($urandom_range(1, 300));
      else if (sel < 8) y = XLEN'(0) - XLEN'($urandom_range(1, 300));
      exp = ref_op(fn[1:0], x, y);
      run_op(fn, x, y, res, z, lat, bc);
      check($sformatf("rand%0d fn=%b a=%h b=%h result", n, fn, x, y),
            res, exp[XLEN-1:0]);
      check($sformatf("rand%0d dz", n), XLEN'(z), XLEN'(exp[XLEN]));
      check($sformatf("rand%0d latency", n), XLEN'(lat),
            (exp[XLEN] || (!fn[0] && x == MIN_NEG && y == '1)) ?
            XLEN'(LAT_S) : XLEN'(LAT_N));
    end

    repeat (3) @(negedge clk);
    check("total done pulses", XLEN'(done_seen), XLEN'(exp_dones));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
